// File: rtl/pcpu_int_pkg.sv
// Shared interrupt-sequencer definitions: FSM state encoding, default vector layout,
// and a helper that sizes the cause index from the IRQ count.
package pcpu_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        SERVICE = 2'd2,
        RESTORE = 2'd3
    } int_state_e;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_1000;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

    function automatic int cause_w(input int num_irq);
        return (num_irq <= 1) ? 1 : $clog2(num_irq);
    endfunction

endpackage

// File: rtl/pipe_int_ctrl_if.sv
// Bundle between the pipeline (master) and the interrupt sequencer (slave):
// IRQ lines, ID-stage flush/PC inputs, and the freeze/restore/context outputs.
interface pipe_int_ctrl_if #(
    parameter int NUM_IRQ = 8,
    parameter int CAUSE_W = 3
);
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               ID_Flush_branch;
    logic               ID_Flush_hazard;
    logic [31:0]        ID_PC;
    logic               int_done;
    logic               INT_detected;
    logic               INT_restore;
    logic [CAUSE_W-1:0] int_cause;
    logic [31:0]        int_epc;
    logic [31:0]        int_vector;
    logic [NUM_IRQ-1:0] int_pending;
    logic               int_wdt_expired;

    modport master (
        output irq, irq_mask, ID_Flush_branch, ID_Flush_hazard, ID_PC, int_done,
        input  INT_detected, INT_restore, int_cause, int_epc, int_vector,
               int_pending, int_wdt_expired
    );

    modport slave (
        input  irq, irq_mask, ID_Flush_branch, ID_Flush_hazard, ID_PC, int_done,
        output INT_detected, INT_restore, int_cause, int_epc, int_vector,
               int_pending, int_wdt_expired
    );
endinterface

// File: rtl/irq_edge_pending.sv
// Purpose: latch IRQ rising edges into a pending register and pick the lowest unmasked one.
// Latency: edge sampled at a clock edge is pending right after it; winner is combinational.
// Backpressure: masked lines stay pending indefinitely; a new edge beats a same-cycle clear.
module irq_edge_pending
    import pcpu_int_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int CAUSE_W = cause_w(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               clr_vld,
    input  logic [CAUSE_W-1:0] clr_idx,
    output logic [NUM_IRQ-1:0] pending,
    output logic               win_vld,
    output logic [CAUSE_W-1:0] win_idx
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] eligible;

    assign rise     = irq & ~irq_q;
    assign clr_mask = clr_vld ? (NUM_IRQ'(1) << clr_idx) : '0;
    assign eligible = pending & ~irq_mask;
    assign win_vld  = |eligible;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~clr_mask) | rise;
        end
    end

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = CAUSE_W'(i);
        end
    end

endmodule

// File: rtl/pipe_int_ctrl.sv
// Purpose: interrupt sequencer freezing ID/EX (INT_detected) and releasing it (INT_restore); INT_WATCHDOG_EN adds a service watchdog.
// Latency: irq edge at t -> pending t+1 -> INT_detected t+2 when idle, unmasked and flush-free.
// Backpressure: entry deferred while ID_Flush_branch/ID_Flush_hazard is high; no nesting, new IRQs only pend.
module pipe_int_ctrl
    import pcpu_int_pkg::*;
#(
    parameter int          NUM_IRQ    = 8,
    parameter int          CAUSE_W    = cause_w(NUM_IRQ),
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
    parameter int          WDT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    pipe_int_ctrl_if.slave bus
);

    int_state_e         state_q, state_d;
    logic               win_vld;
    logic [CAUSE_W-1:0] win_idx;
    logic               accept;
    logic               done_seen_q;
    logic               wdt_hit;

    irq_edge_pending #(
        .NUM_IRQ (NUM_IRQ),
        .CAUSE_W (CAUSE_W)
    ) u_pend (
        .clk      (clk),
        .reset    (reset),
        .irq      (bus.irq),
        .irq_mask (bus.irq_mask),
        .clr_vld  (accept),
        .clr_idx  (win_idx),
        .pending  (bus.int_pending),
        .win_vld  (win_vld),
        .win_idx  (win_idx)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld && !(bus.ID_Flush_branch || bus.ID_Flush_hazard)) begin
                    state_d = ENTER;
                    accept  = 1'b1;
                end
            end
            ENTER:   state_d = SERVICE;
            SERVICE: begin
                if (bus.int_done || done_seen_q || wdt_hit) state_d = RESTORE;
            end
            RESTORE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            done_seen_q    <= 1'b0;
            bus.int_cause  <= '0;
            bus.int_epc    <= '0;
            bus.int_vector <= '0;
        end else begin
            state_q <= state_d;
            // A completion that races ahead during ENTER is held for exactly one cycle.
            done_seen_q <= (state_q == ENTER) && bus.int_done;
            if (accept) begin
                bus.int_cause  <= win_idx;
                bus.int_epc    <= bus.ID_PC;
                bus.int_vector <= VEC_BASE + 32'(win_idx) * VEC_STRIDE;
            end
        end
    end

    assign bus.INT_detected = (state_q == ENTER) || (state_q == SERVICE);
    assign bus.INT_restore  = (state_q == RESTORE);

`ifdef INT_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_exp_q;

    assign wdt_hit = (state_q == SERVICE) && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt   <= '0;
            wdt_exp_q <= 1'b0;
        end else begin
            wdt_cnt <= (state_q == SERVICE) ? wdt_cnt + 1'b1 : '0;
            if (wdt_hit && !(bus.int_done || done_seen_q)) wdt_exp_q <= 1'b1;
        end
    end

    assign bus.int_wdt_expired = wdt_exp_q;
`else
    assign wdt_hit             = 1'b0;
    assign bus.int_wdt_expired = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Directed bench for pipe_int_ctrl: priority, flush deferral, masking, early done,
// reset abort, and (with INT_WATCHDOG_EN) the service watchdog.
module tb_pipe_int_ctrl;
    import pcpu_int_pkg::*;

`ifdef INT_WATCHDOG_EN
    localparam int WDT = 4;
`else
    localparam int WDT = 1024;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pipe_int_ctrl_if #(.NUM_IRQ(8), .CAUSE_W(3)) bif ();

    pipe_int_ctrl #(
        .NUM_IRQ    (8),
        .CAUSE_W    (3),
        .VEC_BASE   (32'h0000_1000),
        .VEC_STRIDE (32'h10),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_fsm(input string tag, input logic det, input logic rst);
        chk({tag, ".det"}, 32'(bif.INT_detected), 32'(det));
        chk({tag, ".rst"}, 32'(bif.INT_restore), 32'(rst));
    endtask

    task automatic finish_service(input string tag);
        tick();
        chk_fsm({tag, ".svc"}, 1'b1, 1'b0);
        bif.int_done = 1'b1;
        tick();
        bif.int_done = 1'b0;
        chk_fsm({tag, ".restore"}, 1'b0, 1'b1);
        tick();
        chk_fsm({tag, ".idle"}, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp               = 0;
        n_err               = 0;
        reset               = 1'b1;
        bif.irq             = '0;
        bif.irq_mask        = '0;
        bif.ID_Flush_branch = 1'b0;
        bif.ID_Flush_hazard = 1'b0;
        bif.ID_PC           = 32'h0000_0100;
        bif.int_done        = 1'b0;
        tick(3);
        reset = 1'b0;
        tick();

        chk_fsm("reset", 1'b0, 1'b0);
        chk("reset.cause", 32'(bif.int_cause), 32'd0);
        chk("reset.epc", bif.int_epc, 32'd0);
        chk("reset.vector", bif.int_vector, 32'd0);
        chk("reset.pending", 32'(bif.int_pending), 32'd0);
        chk("reset.wdt", 32'(bif.int_wdt_expired), 32'd0);

        // 1: single edge on irq[3]
        bif.irq = 8'h08;
        tick();
        chk("t1.pending", 32'(bif.int_pending), 32'h08);
        chk_fsm("t1.t+1", 1'b0, 1'b0);
        tick();
        chk_fsm("t1.enter", 1'b1, 1'b0);
        chk("t1.cause", 32'(bif.int_cause), 32'd3);
        chk("t1.vector", bif.int_vector, 32'h1030);
        chk("t1.epc", bif.int_epc, 32'h100);
        chk("t1.pend_clr", 32'(bif.int_pending), 32'h00);
        finish_service("t1");

        // 2: simultaneous irq[5] and irq[2]
        bif.irq = 8'h00;
        tick();
        bif.irq = 8'h24;
        tick();
        chk("t2.pending", 32'(bif.int_pending), 32'h24);
        tick();
        chk_fsm("t2.enter_a", 1'b1, 1'b0);
        chk("t2.cause_a", 32'(bif.int_cause), 32'd2);
        chk("t2.vector_a", bif.int_vector, 32'h1020);
        chk("t2.pend_a", 32'(bif.int_pending), 32'h20);
        tick();
        bif.int_done = 1'b1;
        tick();
        bif.int_done = 1'b0;
        chk_fsm("t2.restore", 1'b0, 1'b1);
        tick();
        chk_fsm("t2.gap", 1'b0, 1'b0);
        tick();
        chk_fsm("t2.enter_b", 1'b1, 1'b0);
        chk("t2.cause_b", 32'(bif.int_cause), 32'd5);
        chk("t2.vector_b", bif.int_vector, 32'h1050);
        finish_service("t2b");

        // 3: hazard flush high for three cycles defers entry
        bif.irq = 8'h00;
        tick();
        bif.irq             = 8'h02;
        bif.ID_Flush_hazard = 1'b1;
        bif.ID_PC           = 32'h0000_0200;
        tick();
        chk("t3.pending", 32'(bif.int_pending), 32'h02);
        chk_fsm("t3.hold1", 1'b0, 1'b0);
        tick();
        chk_fsm("t3.hold2", 1'b0, 1'b0);
        tick();
        chk_fsm("t3.hold3", 1'b0, 1'b0);
        bif.ID_Flush_hazard = 1'b0;
        bif.ID_PC           = 32'h0000_0204;
        tick();
        chk_fsm("t3.enter", 1'b1, 1'b0);
        chk("t3.cause", 32'(bif.int_cause), 32'd1);
        chk("t3.epc", bif.int_epc, 32'h204);
        finish_service("t3");

        // 4: int_done during ENTER
        bif.irq = 8'h40;
        tick();
        chk("t4.pending", 32'(bif.int_pending), 32'h40);
        tick();
        chk_fsm("t4.enter", 1'b1, 1'b0);
        chk("t4.cause", 32'(bif.int_cause), 32'd6);
        bif.int_done = 1'b1;
        tick();
        bif.int_done = 1'b0;
        chk_fsm("t4.svc", 1'b1, 1'b0);
        tick();
        chk_fsm("t4.restore", 1'b0, 1'b1);
        tick();
        chk_fsm("t4.idle", 1'b0, 1'b0);
        tick();
        chk_fsm("t4.idle2", 1'b0, 1'b0);
        chk("t4.wdt", 32'(bif.int_wdt_expired), 32'd0);
        chk("t4.epc_hold", bif.int_epc, 32'h204);

        // 5: masked line pends without entry; unmask enters; reset aborts service
        bif.irq_mask = 8'h01;
        bif.irq      = 8'h01;
        tick();
        chk("t5.pending", 32'(bif.int_pending), 32'h01);
        tick();
        chk_fsm("t5.masked1", 1'b0, 1'b0);
        tick();
        chk_fsm("t5.masked2", 1'b0, 1'b0);
        chk("t5.pend_hold", 32'(bif.int_pending), 32'h01);
        bif.irq_mask = 8'h00;
        tick();
        chk_fsm("t5.enter", 1'b1, 1'b0);
        chk("t5.cause", 32'(bif.int_cause), 32'd0);
        chk("t5.vector", bif.int_vector, 32'h1000);
        tick();
        chk_fsm("t5.svc", 1'b1, 1'b0);
        bif.irq = 8'h00;
        reset   = 1'b1;
        #1;
        chk_fsm("t5.rst_async", 1'b0, 1'b0);
        chk("t5.rst_epc", bif.int_epc, 32'd0);
        chk("t5.rst_vector", bif.int_vector, 32'd0);
        tick();
        chk_fsm("t5.rst_hold", 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_fsm("t5.after_rst", 1'b0, 1'b0);
        chk("t5.after_pend", 32'(bif.int_pending), 32'd0);

`ifdef INT_WATCHDOG_EN
        // 6: watchdog forces restore after four service cycles
        bif.irq = 8'h10;
        tick(2);
        chk_fsm("t6.enter", 1'b1, 1'b0);
        for (int s = 0; s < 4; s++) begin
            tick();
            chk_fsm("t6.svc", 1'b1, 1'b0);
        end
        tick();
        chk_fsm("t6.restore", 1'b0, 1'b1);
        chk("t6.wdt", 32'(bif.int_wdt_expired), 32'd1);
        tick(2);
        chk_fsm("t6.idle", 1'b0, 1'b0);
        chk("t6.wdt_sticky", 32'(bif.int_wdt_expired), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
